// File: rtl/rmon_update_ctrl.sv
// rmon_update_ctrl
//   Read-modify-write sequencer for port A of the RMON statistics RAM
//   (64 x 32, one-cycle synchronous read). Arbitrates between the Rx and Tx
//   statistics engines (increment) and the CPU clear path (write zero).
//   Port B of the RAM is a free CPU read port and is not handled here.
//
// Ports
//   i_clk, i_reset                 clock shared with the RAM, sync active-high reset
//   i_rx_req/addr/inc, o_rx_ack    Rx increment request, level until ack
//   i_tx_req/addr/inc, o_tx_ack    Tx increment request, level until ack
//   i_clr_req/addr, o_clr_ack      CPU clear request, level until ack
//   o_addra, o_dina, o_wea         RAM port A controls, registered
//   i_douta                        RAM port A read data
//   o_busy                         high whenever the FSM is not IDLE
//
// Parameters
//   SATURATE  0: counters wrap mod 2^32, 1: counters stick at all-ones
//   INC_W     width of the increment operands (at most 32)
module rmon_update_ctrl #(
  parameter bit SATURATE = 1'b0,
  parameter int INC_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_rx_req,
  input  logic [5:0]       i_rx_addr,
  input  logic [INC_W-1:0] i_rx_inc,
  output logic             o_rx_ack,
  input  logic             i_tx_req,
  input  logic [5:0]       i_tx_addr,
  input  logic [INC_W-1:0] i_tx_inc,
  output logic             o_tx_ack,
  input  logic             i_clr_req,
  input  logic [5:0]       i_clr_addr,
  output logic             o_clr_ack,
  output logic [5:0]       o_addra,
  output logic [31:0]      o_dina,
  output logic             o_wea,
  input  logic [31:0]      i_douta,
  output logic             o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_WR, S_CLR} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_rr_rx, w_rr_nxt;     // 1: Rx wins an Rx/Tx tie
  logic [INC_W-1:0] r_inc, w_inc_nxt;
  logic [5:0]       r_addra, w_addra_nxt;  // doubles as the latched address
  logic [31:0]      r_dina, w_dina_nxt;
  logic             r_wea, w_wea_nxt;
  logic             w_rx_ack, w_tx_ack, w_clr_ack;
  logic [32:0]      w_sum;
  logic [31:0]      w_upd;

  // Douta is valid in WT; the updated count is registered straight into Dina.
  assign w_sum = {1'b0, i_douta} + 33'(r_inc);
  assign w_upd = (SATURATE && w_sum[32]) ? 32'hFFFF_FFFF : w_sum[31:0];

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_rx;
    w_inc_nxt   = r_inc;
    w_addra_nxt = r_addra;
    w_dina_nxt  = r_dina;
    w_wea_nxt   = 1'b0;
    w_rx_ack    = 1'b0;
    w_tx_ack    = 1'b0;
    w_clr_ack   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Grants are suppressed during reset so no ack is lost to it.
        if (!i_reset) begin
          if (i_clr_req) begin
            // Clear wins outright and leaves the round-robin pointer alone.
            w_clr_ack   = 1'b1;
            w_state_nxt = S_CLR;
            w_addra_nxt = i_clr_addr;
            w_dina_nxt  = '0;
            w_inc_nxt   = '0;
            w_wea_nxt   = 1'b1;
          end else if (i_rx_req && (r_rr_rx || !i_tx_req)) begin
            w_rx_ack    = 1'b1;
            w_state_nxt = S_RD;
            w_addra_nxt = i_rx_addr;
            w_inc_nxt   = i_rx_inc;
            w_rr_nxt    = 1'b0;
          end else if (i_tx_req) begin
            w_tx_ack    = 1'b1;
            w_state_nxt = S_RD;
            w_addra_nxt = i_tx_addr;
            w_inc_nxt   = i_tx_inc;
            w_rr_nxt    = 1'b1;
          end
        end
      end
      S_RD:  w_state_nxt = S_WT;
      S_WT: begin
        w_state_nxt = S_WR;
        w_dina_nxt  = w_upd;
        w_wea_nxt   = 1'b1;
      end
      S_WR:  w_state_nxt = S_IDLE;
      S_CLR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_rr_rx <= 1'b1;
      r_inc   <= '0;
      r_addra <= '0;
      r_dina  <= '0;
      r_wea   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rr_rx <= w_rr_nxt;
      r_inc   <= w_inc_nxt;
      r_addra <= w_addra_nxt;
      r_dina  <= w_dina_nxt;
      r_wea   <= w_wea_nxt;
    end
  end

  assign o_rx_ack  = w_rx_ack;
  assign o_tx_ack  = w_tx_ack;
  assign o_clr_ack = w_clr_ack;
  assign o_addra   = r_addra;
  assign o_dina    = r_dina;
  assign o_wea     = r_wea;
  assign o_busy    = (r_state != S_IDLE);

endmodule

// File: doc/rmon_update_ctrl.md
Name: rmon_update_ctrl

Overview:
- Sequences read-modify-write updates of the RMON statistics RAM through its port A (6-bit address, 32-bit data, synchronous one-cycle read).
- Arbitrates between three requesters:
  - Rx statistics engine (increment)
  - Tx statistics engine (increment)
  - CPU counter-clear path (write zero).
- Port B of the RAM stays a free CPU read port and is not touched by this block.

Parameters:
- SATURATE, 0, 0 = counters wrap modulo 2^32; 1 = counters stick at 32'hFFFF_FFFF.
- INC_W, 16, width of the Rx/Tx increment operands.

Ports:
- Clk  input  1  single clock, same clock as the RAM.
- Reset  input  1  synchronous, active-high reset.
- Rx_req  input  1  Rx update request, level, held until Rx_ack.
- Rx_addr  input  6  counter address for Rx request.
- Rx_inc  input  INC_W  increment value for Rx request.
- Rx_ack  output  1  one-cycle grant pulse; Rx_addr/Rx_inc are captured this cycle.
- Tx_req  input  1  Tx update request, same rules as Rx.
- Tx_addr  input  6  counter address for Tx request.
- Tx_inc  input  INC_W  increment value for Tx request.
- Tx_ack  output  1  one-cycle grant pulse for Tx.
- Clr_req  input  1  CPU clear request, level, held until Clr_ack.
- Clr_addr  input  6  counter address to clear.
- Clr_ack  output  1  one-cycle grant pulse for clear.
- Addra  output  6  RAM port A address, registered.
- Dina  output  32  RAM port A write data, registered.
- Wea  output  1  RAM port A write enable, registered.
- Douta  input  32  RAM port A read data, valid the cycle after Addra is presented with Wea=0.
- Busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset values:
  - Addra=0, Dina=0, Wea=0.
  - Rx_ack=Tx_ack=Clr_ack=0, Busy=0.
  - FSM=IDLE; round-robin pointer = Rx-first.
- FSM states: IDLE, RD, WT, WR, CLR.
- IDLE:
  - If any request is present, grant exactly one, pulse its ack for one cycle and latch its addr/inc (clear latches inc=0).
  - Priority: Clr highest, then round-robin between Rx and Tx. The pointer flips to the other requester after each Rx/Tx grant; a clear grant does not move it.
  - On grant, next state is CLR for a clear and RD for Rx/Tx. Otherwise stay in IDLE.
- RD: Addra=latched addr, Wea=0 → WT.
- WT:
  - Douta is valid in this state.
  - Register sum = Douta + zero-extended inc, computed in 33 bits.
  - SATURATE=0: keep low 32 bits. SATURATE=1: bit 32 set → 32'hFFFF_FFFF.
  - → WR.
- WR: Addra=latched addr, Dina=sum, Wea=1 for exactly one cycle → IDLE.
- CLR: Addra=latched addr, Dina=0, Wea=1 for one cycle → IDLE.
- Latency and throughput:
  - Increment: ack → write takes 4 cycles (IDLE grant, RD, WT, WR). Sustained rate is one increment per 4 cycles.
  - Clear: 2 cycles (IDLE grant, CLR).
- Wea is never high outside WR/CLR. Addra holds its last value in IDLE with Wea=0.
- Acks are only ever asserted in IDLE, and at most one ack is high in any cycle.
- Requester rules:
  - A requester may present a new request the cycle after its ack.
  - Dropping req before ack withdraws the request, with no side effect.
- Same address back-to-back (Rx then Tx, or repeated): the second read happens after the first write has completed, so no update is lost. No bypass logic is required.
- Clear vs increment on the same address:
  - A clear pending while an increment is in RD/WT/WR waits until IDLE. The increment completes first, then the clear zeroes the counter.
  - A clear and an increment requested in the same IDLE cycle: the clear goes first, then the increment applies to 0.
- Reset mid-operation: FSM → IDLE next cycle. Wea=0 from that cycle on; any in-flight write is abandoned (no partial write). Acks already given are not repeated.
- Address range 0..63, no range checking; address 63 is a valid counter.

Test Plan:
- RAM word 5 = 32'h0000_0010; Rx_req with addr=5, inc=16'h0040 → Rx_ack one pulse; Wea high exactly 3 cycles after ack with Addra=5, Dina=32'h0000_0050.
- Rx_req and Tx_req both held, addr=1 and addr=2, inc=1, 6 updates each → grants alternate Rx,Tx,Rx,…; final words 1 and 2 each +6; one ack per 4 cycles.
- Rx and Tx both held on addr=9, inc=3, word 9 starting at 0, 10 grants total → word 9 = 30 (no lost update).
- Word 7 = 32'hFFFF_FFF0, increment 32: SATURATE=0 → 32'h0000_0010; SATURATE=1 → 32'hFFFF_FFFF.
- Clr_req addr=5 asserted alongside Rx_req addr=5 inc=4, word 5=100 → Clr_ack first, Wea with Dina=0 next cycle, then Rx update; final word 5 = 4.
- Reset asserted while FSM is in WT → no Wea pulse; next cycle all outputs at reset values; RAM word unchanged; a new request afterwards is served normally.
